// File: rtl/lcd_msg_feeder.sv
// lcd_msg_feeder: FIFO-buffered byte feeder that paces single-cycle strobes
// to an LCD text driver with a fixed post-strobe gap.
module lcd_msg_feeder #(
    parameter int          DEPTH = 16,
    parameter logic [15:0] GAP   = 16'd2000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     init_complete,
    output logic                     ready,
    output logic [7:0]               msg_byte,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_t;

    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   cnt_q;
    logic          ready_q, busy_q;
    logic [7:0]    msg_q;
    logic          push, pop;

    assign in_ready = level_q != LW'(DEPTH);
    assign push     = in_valid && in_ready;
    // Pops only from IDLE with data present, so a push into empty never collides
    assign pop      = state_q == IDLE && init_complete && level_q != '0;
    assign level_d  = level_q + LW'(push) - LW'(pop);

    assign ready    = ready_q;
    assign msg_byte = msg_q;
    assign busy     = busy_q;
    assign level    = level_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            msg_q    <= 8'h00;
        end else begin
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            case (state_q)
                IDLE: if (pop) begin
                    msg_q    <= mem_q[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    busy_q   <= 1'b1;
                    state_q  <= LOAD;
                end
                LOAD: begin
                    ready_q <= 1'b1;
                    state_q <= STROBE;
                end
                STROBE: begin
                    ready_q <= 1'b0;
                    cnt_q   <= GAP - 16'd1;
                    state_q <= HOLD;
                end
                HOLD: if (cnt_q == 16'd0) begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - 16'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_msg_feeder.sv
// tb_lcd_msg_feeder: directed checks of buffering, pacing, init gating and reset.
module tb_lcd_msg_feeder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       init_complete = 1'b1;
    logic       ready;
    logic [7:0] msg_byte;
    logic       busy;
    logic [2:0] level;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int sc[$];
    logic [7:0] sd[$];
    logic prev_ready = 1'b0;
    logic [7:0] prev_msg = 8'h00;
    logic [2:0] lvl_max = '0;

    lcd_msg_feeder #(.DEPTH(4), .GAP(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .init_complete(init_complete), .ready(ready),
        .msg_byte(msg_byte), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (t >= 50) chk("push_timeout", 32'd1, 32'd0);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        sc.delete();
        sd.delete();
    endtask

    always @(posedge clk) cyc++;

    // Strobe logger: one-cycle pulse and data stable from the preceding cycle
    always @(negedge clk) begin
        if (ready) begin
            chk("ready_pulse", {31'd0, prev_ready}, 32'd0);
            chk("msg_setup", {24'd0, msg_byte}, {24'd0, prev_msg});
            sc.push_back(cyc);
            sd.push_back(msg_byte);
        end
        if (level > lvl_max) lvl_max = level;
        prev_ready = ready;
        prev_msg   = msg_byte;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v[6];
        // Reset values
        tick(2);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_msg", {24'd0, msg_byte}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick(2);

        // Single byte latency
        clear_log();
        in_valid = 1'b1; in_data = 8'h48;
        tick(1);
        in_valid = 1'b0;
        chk("t1_level_k", {29'd0, level}, 32'd1);
        chk("t1_busy_k", {31'd0, busy}, 32'd0);
        tick(1);
        chk("t1_level_k1", {29'd0, level}, 32'd0);
        chk("t1_busy_k1", {31'd0, busy}, 32'd1);
        chk("t1_msg_k1", {24'd0, msg_byte}, 32'h48);
        chk("t1_ready_k1", {31'd0, ready}, 32'd0);
        tick(1);
        chk("t1_ready_k2", {31'd0, ready}, 32'd1);
        chk("t1_msg_k2", {24'd0, msg_byte}, 32'h48);
        tick(1);
        chk("t1_ready_k3", {31'd0, ready}, 32'd0);
        tick(3);
        chk("t1_busy_k6", {31'd0, busy}, 32'd1);
        tick(1);
        chk("t1_busy_k7", {31'd0, busy}, 32'd0);
        chk("t1_msg_idle", {24'd0, msg_byte}, 32'h48);
        chk("t1_strobes", sc.size(), 32'd1);

        // "HI!" back-to-back
        tick(3);
        clear_log();
        in_valid = 1'b1;
        in_data = 8'h48; tick(1);
        in_data = 8'h49; tick(1);
        in_data = 8'h21; tick(1);
        in_valid = 1'b0;
        tick(30);
        chk("t2_strobes", sc.size(), 32'd3);
        if (sc.size() == 3) begin
            chk("t2_b0", {24'd0, sd[0]}, 32'h48);
            chk("t2_b1", {24'd0, sd[1]}, 32'h49);
            chk("t2_b2", {24'd0, sd[2]}, 32'h21);
            chk("t2_gap01", sc[1] - sc[0], 32'd7);
            chk("t2_gap12", sc[2] - sc[1], 32'd7);
        end

        // Init held low: saturate and drop 5th byte
        clear_log();
        init_complete = 1'b0;
        v[0] = 8'h41; v[1] = 8'h42; v[2] = 8'h43; v[3] = 8'h44; v[4] = 8'h45;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = v[i];
            tick(1);
            chk("t3_level", {29'd0, level}, (i < 4) ? i + 1 : 4);
        end
        in_valid = 1'b0;
        chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        tick(10);
        chk("t3_no_strobe", sc.size(), 32'd0);
        chk("t3_idle_busy", {31'd0, busy}, 32'd0);
        init_complete = 1'b1;
        tick(35);
        chk("t3_strobes", sc.size(), 32'd4);
        if (sc.size() == 4)
            for (int i = 0; i < 4; i++) chk("t3_data", {24'd0, sd[i]}, {24'd0, v[i]});
        chk("t3_level_end", {29'd0, level}, 32'd0);

        // Fill and wrap while draining
        clear_log();
        lvl_max = '0;
        v[0] = 8'h10; v[1] = 8'h11; v[2] = 8'h12; v[3] = 8'h13; v[4] = 8'h14; v[5] = 8'h15;
        for (int i = 0; i < 6; i++) push_byte(v[i]);
        tick(50);
        chk("t4_strobes", sc.size(), 32'd6);
        if (sc.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk("t4_data", {24'd0, sd[i]}, {24'd0, v[i]});
                if (i > 0) chk("t4_gap", sc[i] - sc[i-1], 32'd7);
            end
        chk("t4_lvl_max_ok", {31'd0, lvl_max <= 3'd4}, 32'd1);
        chk("t4_lvl_full_seen", {29'd0, lvl_max}, 32'd4);

        // Drop init during HOLD of byte 1
        clear_log();
        in_valid = 1'b1;
        in_data = 8'h61; tick(1);
        in_data = 8'h62; tick(1);
        in_data = 8'h63; tick(1);
        in_valid = 1'b0;
        tick(2);
        init_complete = 1'b0;
        tick(12);
        chk("t5_level_park", {29'd0, level}, 32'd2);
        chk("t5_busy_park", {31'd0, busy}, 32'd0);
        chk("t5_strobes_park", sc.size(), 32'd1);
        if (sc.size() == 1) chk("t5_b0", {24'd0, sd[0]}, 32'h61);
        init_complete = 1'b1;
        tick(20);
        chk("t5_strobes", sc.size(), 32'd3);
        if (sc.size() == 3) begin
            chk("t5_b1", {24'd0, sd[1]}, 32'h62);
            chk("t5_b2", {24'd0, sd[2]}, 32'h63);
        end

        // Async reset during STROBE
        clear_log();
        in_valid = 1'b1; in_data = 8'h77;
        tick(1);
        in_valid = 1'b0;
        tick(2);
        chk("t6_ready_pre", {31'd0, ready}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_ready_async", {31'd0, ready}, 32'd0);
        chk("t6_busy_async", {31'd0, busy}, 32'd0);
        chk("t6_level_async", {29'd0, level}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("t6_no_strobe", sc.size(), 32'd0);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);
        push_byte(8'h5a);
        tick(10);
        chk("t6_new_strobe", sc.size(), 32'd1);
        if (sc.size() == 1) chk("t6_new_data", {24'd0, sd[0]}, 32'h5a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_msg_feeder.md
# lcd_msg_feeder

Buffers text bytes from a producer (UART receiver, ROM sequencer, host logic) in a small FIFO. Paces them out to the LCD text driver's `ready`/`msg_byte` inputs, one single-cycle strobe per byte. The LCD driver has no busy/acknowledge output, so this block enforces a fixed inter-byte gap. It only issues bytes once the driver reports `init_complete`. It sits directly upstream of the display driver.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, ≥2.
- `GAP`, 16'd2000: HOLD-state cycles after each strobe. Must be ≥1. Sized to cover the driver's per-byte write time.
- `clk` input 1: single clock. All logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer offers `in_data` this cycle.
- `in_data` input 8: character byte.
- `in_ready` output 1: combinational, `level != DEPTH`. A push happens when `in_valid && in_ready`.
- `init_complete` input 1: the LCD driver has finished its init sequence.
- `ready` output 1: registered, one-cycle strobe to the driver.
- `msg_byte` output 8: registered byte to the driver. Stable from the LOAD edge through the end of HOLD.
- `busy` output 1: registered, high whenever the FSM is not in IDLE.
- `level` output $clog2(DEPTH)+1: registered FIFO occupancy.

## Operation
- FIFO: circular buffer with write and read pointers of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH. `level` counts 0..DEPTH.
- Push when `in_valid && in_ready`: write `in_data` at the write pointer, then increment it. A push while full is ignored; nothing is written and no pointer moves.
- FSM states are IDLE, LOAD, STROBE, HOLD.
  - IDLE → LOAD when `init_complete && level != 0`. On that edge: `msg_byte <= fifo[rd_ptr]`, increment the read pointer (pop), `busy <= 1`.
  - LOAD → STROBE unconditionally, with `ready <= 1`. LOAD gives the driver one setup cycle with data stable before the strobe.
  - STROBE → HOLD unconditionally, with `ready <= 0` and the gap counter loaded with GAP-1.
  - HOLD: decrement the counter each cycle. When it reaches 0, go to IDLE with `busy <= 0`.
- Simultaneous push and pop in the same cycle is legal at any nonzero level. `level` stays unchanged. Because the pop only happens from IDLE with `level != 0`, a push into an empty FIFO can never collide with a pop.
- Full FIFO with a pop in the same cycle: `in_ready` is still 0 that cycle, so the push is refused. The producer retries next cycle.
- If `init_complete` deasserts mid-byte, the in-flight byte completes LOAD/STROBE/HOLD normally. The FSM then waits in IDLE. Buffered bytes are retained.
- `msg_byte` holds its last value in IDLE and does not return to 0.
- Reset is asynchronous and takes effect immediately, mid-operation included. The FIFO empties and any in-flight byte is abandoned with no strobe issued.

## Timing
- Reset values:
  - `ready` = 0, `msg_byte` = 8'h00, `busy` = 0, `level` = 0.
  - Pointers 0, gap counter 0, state IDLE.
  - `in_ready` = 1, since it is combinational on `level`.
- Push at edge k into an empty FIFO with `init_complete` high:
  - `level` = 1 after edge k.
  - IDLE→LOAD at edge k+1: `msg_byte` valid and `level` = 0 after k+1.
  - STROBE at edge k+2: `ready` high for exactly the cycle between edges k+2 and k+3.
  - HOLD from k+3. IDLE is reached at edge k+3+GAP.
- Back-to-back bytes: the rising edges of consecutive `ready` pulses are exactly GAP+3 cycles apart.
- `ready` is never high for more than one consecutive cycle. `msg_byte` never changes while `ready` is high.
- Pushes continue at one per cycle regardless of FSM state until the FIFO is full.

## Test plan
Bench configuration: DEPTH=4, GAP=4.
- Reset with `init_complete`=1, then push 8'h48 at edge 10 → `ready` high in the cycle after edge 12 with `msg_byte`=8'h48. `busy` falls at edge 17. `level` returns to 0 at edge 11.
- Push "HI!" (8'h48, 8'h49, 8'h21) back-to-back → three strobes with rising edges 7 cycles apart, in order. No extra strobes.
- Hold `init_complete`=0 and push 5 bytes → `level` saturates at 4, `in_ready`=0, the 5th byte is dropped, and there are no strobes. Raise `init_complete` → exactly 4 strobes carrying the first 4 bytes.
- Fill the FIFO and wrap the pointers: push 6 bytes while draining (init high) → output order matches input order across the pointer wrap. Check `level` never exceeds 4.
- Drop `init_complete` during HOLD of byte 1 of 3 → byte 1 completes, the FSM parks in IDLE with `level`=2. Re-raising `init_complete` resumes with byte 2.
- Assert `rst_n`=0 during STROBE → `ready` and `busy` go to 0 immediately (asynchronously) and `level` goes to 0. After release, no strobe occurs until a new push.
